bit_reorder_pipe: RTL

BIT_REORDER_PIPE -- requirements
Module: bit_reorder_pipe

---
 rtl/bit_reorder_pipe.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bit_reorder_pipe.sv
// bit_reorder_pipe: per-word bit reorder (pass, reverse, group reverse, rotate)
// feeding a two-entry output buffer with registered ready and a transfer count.
module bit_reorder_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 1,
  parameter int CNT_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [WIDTH-1:0]         D_IN,
  input  logic [1:0]               MODE,
  input  logic [$clog2(WIDTH)-1:0] ROT,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [WIDTH-1:0]         D_OUT,
  output logic [CNT_W-1:0]         XFER_CNT
);

  localparam int NG = WIDTH / GROUP;
  localparam int RW = $clog2(WIDTH);
  localparam logic [RW:0] WIDTH_E = WIDTH[RW:0];

  if (GROUP < 1 || WIDTH < 2 || (WIDTH % GROUP) != 0) begin : g_bad_param
    $error("bit_reorder_pipe: WIDTH must be >=2 and a multiple of GROUP");
  end

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] rev_bits;
  logic [WIDTH-1:0] rev_grp;
  logic [WIDTH-1:0] rot_word;
  logic [WIDTH-1:0] xf;
  logic [RW:0]      rot_ext;
  logic [RW:0]      rot_amt;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer   = IN_VALID & in_ready_q;
  assign out_xfer  = OUT_READY & (state_q != S_EMPTY);
  assign IN_READY  = in_ready_q;
  assign OUT_VALID = (state_q != S_EMPTY);
  assign D_OUT     = main_q;
  assign XFER_CNT  = cnt_q;

  // Mirror every bit about the word centre.
  always_comb begin
    rev_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev_bits[WIDTH-1-i] = D_IN[i];
    end
  end

  // Mirror whole groups, keeping bit order inside each group.
  always_comb begin
    rev_grp = '0;
    for (int k = 0; k < NG; k++) begin
      rev_grp[(NG-1-k)*GROUP +: GROUP] = D_IN[k*GROUP +: GROUP];
    end
  end

  // Rotate left; ROT can exceed WIDTH-1 only by less than WIDTH, so one
  // conditional subtract reduces it modulo WIDTH.
  always_comb begin
    rot_ext  = {1'b0, ROT};
    rot_amt  = (rot_ext >= WIDTH_E) ? rot_ext - WIDTH_E : rot_ext;
    rot_word = (D_IN << rot_amt) | (D_IN >> (WIDTH_E - rot_amt));
  end

  // Select the transform for the word being accepted.
  always_comb begin
    xf = D_IN;
    unique case (MODE)
      2'b00: xf = D_IN;
      2'b01: xf = rev_bits;
      2'b10: xf = rev_grp;
      2'b11: xf = rot_word;
    endcase
  end

  // Buffer occupancy next-state and main/skid next contents.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          state_d = S_ONE;
          main_d  = xf;
        end
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = xf;
        end else if (in_xfer) begin
          state_d = S_TWO;
          skid_d  = xf;
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_xfer) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State, data and ready registers; ready comes from next state only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != S_TWO);
    end
  end

  // Count delivered words, wrapping naturally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (out_xfer) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
